// File: rtl/cond_pkg.sv
// Shared constants for the condition/flag unit: condition codes, flag bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cond_pkg;

  // 4-bit branch/predication condition codes
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Bit positions inside the {C,N,V,Z} status word
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Result FSM: IDLE has no result outstanding, RESULT holds one for the consumer
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Bundles the ALU flag inputs, EX write qualifiers and the ID request/result handshake.
// Latency: n/a (wiring only).
// Backpressure: res_ready from the consumer gates req_ready inside the unit.
interface cond_flag_unit_if;

  logic       alu_c;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic       ex_valid;
  logic       ex_s_bit;
  logic       stall_in;
  logic       req_valid;
  logic [3:0] req_cond;
  logic       req_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;

  // Pipeline side: drives flags, requests and result acceptance
  modport master (
    output alu_c, alu_n, alu_v, alu_z,
    output ex_valid, ex_s_bit, stall_in,
    output req_valid, req_cond, res_ready,
    input  req_ready, res_valid, res_taken
  );

  // Flag unit side
  modport slave (
    input  alu_c, alu_n, alu_v, alu_z,
    input  ex_valid, ex_s_bit, stall_in,
    input  req_valid, req_cond, res_ready,
    output req_ready, res_valid, res_taken
  );

endinterface

// File: rtl/cond_flag_unit_eval.sv
// Combinational condition evaluator: 4-bit condition code against {C,N,V,Z} -> taken.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; also used by the predicated-execution path.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic c, n, v, z;

  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  // Decode the condition table
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Status register {C,N,V,Z} plus condition resolver for ID, with same-cycle EX flag forwarding.
// Latency: request accepted at edge k -> res_valid/res_taken visible in cycle k+1.
// Backpressure: result held while res_ready=0; req_ready = idle | res_ready.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         BYPASS_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  cond_flag_unit_if.slave  bus,
  output logic [3:0]       flags,
  output logic             cin_out
);

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic [3:0] alu_flags;
  logic [3:0] eval_flags;
  logic       wr;
  logic       accept;
  logic       eval_taken;
  logic       taken_q, taken_d;

  assign wr        = bus.ex_valid & bus.ex_s_bit & ~bus.stall_in;
  assign alu_flags = {bus.alu_c, bus.alu_n, bus.alu_v, bus.alu_z};

  // Forwarding only feeds the evaluator; the Cin path always sees the register
  assign eval_flags = (BYPASS_EN && wr) ? alu_flags : flags_q;

  assign bus.req_ready = (state_q == ST_IDLE) | bus.res_ready;
  assign accept        = bus.req_valid & bus.req_ready;

  assign flags         = flags_q;
  assign cin_out       = flags_q[FLAG_C];
  assign bus.res_valid = (state_q == ST_RESULT);
  assign bus.res_taken = taken_q;

  cond_eval u_eval (
    .cond  (bus.req_cond),
    .flags (eval_flags),
    .taken (eval_taken)
  );

  // Architectural status register, updated by unstalled S-bit instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
    end else if (wr) begin
      flags_q <= alu_flags;
    end
  end

  // Result FSM next state; a held result ignores later flag writes
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESULT;
          taken_d = eval_taken;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          if (bus.req_valid) begin
            state_d = ST_RESULT;
            taken_d = eval_taken;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: one forwarding instance and one register-only instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises res_ready=0 holds and back-to-back results.
module tb_cond_flag_unit;
  import cond_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags1, flags0;
  logic       cin1, cin0;
  int         n_cmp;
  int         n_err;

  cond_flag_unit_if bus1 ();
  cond_flag_unit_if bus0 ();

  cond_flag_unit #(.RESET_FLAGS(4'b0000), .BYPASS_EN(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1.slave),
    .flags   (flags1),
    .cin_out (cin1)
  );

  cond_flag_unit #(.RESET_FLAGS(4'b0000), .BYPASS_EN(1'b0)) dut_nobyp (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus0.slave),
    .flags   (flags0),
    .cin_out (cin0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu1(input logic [3:0] f, input logic we);
    {bus1.alu_c, bus1.alu_n, bus1.alu_v, bus1.alu_z} = f;
    bus1.ex_valid = we;
    bus1.ex_s_bit = we;
  endtask

  logic [15:0] tbl_exp;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    alu1(4'b0000, 1'b0);
    bus1.stall_in = 1'b0; bus1.req_valid = 1'b0; bus1.req_cond = 4'd0; bus1.res_ready = 1'b1;
    {bus0.alu_c, bus0.alu_n, bus0.alu_v, bus0.alu_z} = 4'b0000;
    bus0.ex_valid = 1'b0; bus0.ex_s_bit = 1'b0; bus0.stall_in = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_cond = 4'd0; bus0.res_ready = 1'b1;
    step();
    step();
    chk("rst_flags", flags1, 4'b0000);
    chk("rst_res_valid", {3'b0, bus1.res_valid}, 4'd0);
    chk("rst_res_taken", {3'b0, bus1.res_taken}, 4'd0);
    #2 rst_n = 1'b1;
    #1 chk("rst_req_ready", {3'b0, bus1.req_ready}, 4'd1);

    // 1: load 1010 then async reset mid-cycle
    alu1(4'b1010, 1'b1);
    step();
    chk("t1_flags_loaded", flags1, 4'b1010);
    alu1(4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("t1_async_flags", flags1, 4'b0000);
    chk("t1_async_res_valid", {3'b0, bus1.res_valid}, 4'd0);
    #1 rst_n = 1'b1;

    // 2: write C=1,Z=1 then stalled write is blocked
    alu1(4'b1001, 1'b1);
    step();
    chk("t2_flags", flags1, 4'b1001);
    chk("t2_cin", {3'b0, cin1}, 4'd1);
    alu1(4'b0110, 1'b1);
    bus1.stall_in = 1'b1;
    step();
    chk("t2_stall_hold", flags1, 4'b1001);
    bus1.stall_in = 1'b0;

    // 3: overflow flags written in the same cycle as a GE request
    alu1(4'b0110, 1'b1);
    bus1.req_valid = 1'b1; bus1.req_cond = COND_GE;
    {bus0.alu_c, bus0.alu_n, bus0.alu_v, bus0.alu_z} = 4'b0100;
    bus0.ex_valid = 1'b1; bus0.ex_s_bit = 1'b1;
    bus0.req_valid = 1'b1; bus0.req_cond = COND_GE;
    step();
    chk("t3_byp_valid", {3'b0, bus1.res_valid}, 4'd1);
    chk("t3_byp_ge", {3'b0, bus1.res_taken}, 4'd1);
    chk("t3_flags", flags1, 4'b0110);
    chk("t3_nobyp_ge_old", {3'b0, bus0.res_taken}, 4'd1);
    chk("t3_nobyp_flags", flags0, 4'b0100);
    alu1(4'b0000, 1'b0);
    bus1.req_cond = COND_LT;
    bus0.ex_valid = 1'b0; bus0.ex_s_bit = 1'b0;
    step();
    chk("t3_lt", {3'b0, bus1.res_taken}, 4'd0);
    chk("t3_nobyp_ge_new", {3'b0, bus0.res_taken}, 4'd0);
    bus1.req_valid = 1'b0;
    bus0.req_valid = 1'b0;
    step();
    chk("t3_idle", {3'b0, bus1.res_valid}, 4'd0);

    // 4: N-only flags, sweep all conditions back to back
    alu1(4'b0100, 1'b1);
    step();
    alu1(4'b0000, 1'b0);
    chk("t4_flags", flags1, 4'b0100);
    tbl_exp = 16'b0110_1010_1001_1010; // bit i = expected taken for cond i
    for (int i = 0; i < 16; i++) begin
      bus1.req_valid = 1'b1;
      bus1.req_cond = 4'(i);
      #1 chk($sformatf("t4_ready_%0d", i), {3'b0, bus1.req_ready}, 4'd1);
      step();
      chk($sformatf("t4_valid_%0d", i), {3'b0, bus1.res_valid}, 4'd1);
      chk($sformatf("t4_taken_%0d", i), {3'b0, bus1.res_taken}, {3'b0, tbl_exp[i]});
    end
    bus1.req_valid = 1'b0;
    step();
    chk("t4_idle", {3'b0, bus1.res_valid}, 4'd0);

    // 5: hold a result under backpressure while flags change
    bus1.req_valid = 1'b1; bus1.req_cond = COND_MI; bus1.res_ready = 1'b0;
    step();
    bus1.req_cond = COND_NV;
    alu1(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t5_req_ready_%0d", i), {3'b0, bus1.req_ready}, 4'd0);
      chk($sformatf("t5_valid_%0d", i), {3'b0, bus1.res_valid}, 4'd1);
      chk($sformatf("t5_taken_%0d", i), {3'b0, bus1.res_taken}, 4'd1);
      step();
    end
    chk("t5_flags_changed", flags1, 4'b0000);
    chk("t5_taken_after", {3'b0, bus1.res_taken}, 4'd1);
    alu1(4'b0000, 1'b0);
    bus1.req_valid = 1'b0; bus1.res_ready = 1'b1;
    #1 chk("t5_ready_release", {3'b0, bus1.req_ready}, 4'd1);
    step();
    chk("t5_drained", {3'b0, bus1.res_valid}, 4'd0);

    // 6: reset while a result is pending, then a normal request
    bus1.req_valid = 1'b1; bus1.req_cond = COND_AL; bus1.res_ready = 1'b0;
    step();
    chk("t6_pending", {3'b0, bus1.res_valid}, 4'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", {3'b0, bus1.res_valid}, 4'd0);
    chk("t6_rst_taken", {3'b0, bus1.res_taken}, 4'd0);
    #1 rst_n = 1'b1;
    bus1.req_cond = COND_CC; bus1.res_ready = 1'b1;
    step();
    chk("t6_after_valid", {3'b0, bus1.res_valid}, 4'd1);
    chk("t6_after_cc", {3'b0, bus1.res_taken}, 4'd1);
    bus1.req_valid = 1'b0;
    step();
    chk("t6_final_idle", {3'b0, bus1.res_valid}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
